// File: rtl/ps2_key_tracker_if.sv
// ps2_key_tracker_if: pop handshake between the PS/2 controller FIFO and the
// key tracker.
//   ready      : FIFO non-empty, data valid while high   (controller -> tracker)
//   data[7:0]  : FIFO head byte                          (controller -> tracker)
//   nextdata_n : active-low pop strobe                   (tracker -> controller)
interface ps2_key_tracker_if;
  logic       ready;
  logic [7:0] data;
  logic       nextdata_n;

  modport master (output ready, output data, input nextdata_n);
  modport slave  (input ready, input data, output nextdata_n);
endinterface

// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker: pops Set-2 scan-code bytes from the PS/2 controller FIFO,
// decodes the E0 (extended) and F0 (break) prefixes into 9-bit key codes
// {ext, byte}, and keeps a table of up to MAX_KEYS held keys.
//
// Optional feature macro: PS2_TRK_REPEAT_EN
//   defined   : a make of an already-held key emits a repeat event
//   undefined : such makes are consumed silently, event_repeat tied 0
//
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   bus (slave)   : ready / data / nextdata_n FIFO pop handshake
//   event_valid   : one-cycle pulse, key event reported
//   event_make    : 1 = make, 0 = break
//   event_repeat  : typematic repeat of a held key
//   event_code    : {ext, scan byte} of the event
//   last_code     : code of the most recent make event (repeats included)
//   held_any      : at least one key held
//   held_num      : number of keys in the table
//   press_cnt     : fresh make count, wraps
//   drop_err      : sticky, a make was dropped because the table was full
//   kbd_err       : sticky, byte 00 or FF received
module ps2_key_tracker #(
  parameter int MAX_KEYS = 4,
  parameter int CNT_W    = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  ps2_key_tracker_if.slave              bus,
  output logic                          event_valid,
  output logic                          event_make,
  output logic                          event_repeat,
  output logic [8:0]                    event_code,
  output logic [8:0]                    last_code,
  output logic                          held_any,
  output logic [$clog2(MAX_KEYS+1)-1:0] held_num,
  output logic [CNT_W-1:0]              press_cnt,
  output logic                          drop_err,
  output logic                          kbd_err
);

  localparam int HW = $clog2(MAX_KEYS + 1);

  typedef enum logic [1:0] {IDLE, POP, WAIT} state_t;

  state_t state, state_nx;

  logic       nextdata_q;
  logic [7:0] byte_q;
  logic       ext_q, brk_q;
  logic       ext_nx, brk_nx;

  logic [MAX_KEYS-1:0] slot_vld;
  logic [8:0]          slot_code [MAX_KEYS];

  logic [8:0]          cur_code;
  logic [MAX_KEYS-1:0] hit;
  logic [MAX_KEYS-1:0] ins_oh;
  logic                found_free;
  logic                hit_any;
  logic [HW-1:0]       held_cnt;

  logic dec_fire, dec_make, dec_upd_last, dec_new;
  logic dec_ins, dec_rem, dec_drop, dec_kerr;
`ifdef PS2_TRK_REPEAT_EN
  logic dec_rep;
`endif

  assign cur_code       = {ext_q, byte_q};
  assign bus.nextdata_n = nextdata_q;
  assign held_num       = held_cnt;
  assign held_any       = (held_cnt != '0);

  // Key lookup against all valid slots, and lowest free slot as one-hot.
  always_comb begin
    hit        = '0;
    ins_oh     = '0;
    found_free = 1'b0;
    for (int unsigned i = 0; i < MAX_KEYS; i++) begin
      hit[i] = slot_vld[i] && (slot_code[i] == cur_code);
      if (!slot_vld[i] && !found_free) begin
        ins_oh[i]  = 1'b1;
        found_free = 1'b1;
      end
    end
  end

  assign hit_any = |hit;

  always_comb begin
    held_cnt = '0;
    for (int unsigned i = 0; i < MAX_KEYS; i++)
      held_cnt = held_cnt + HW'(slot_vld[i]);
  end

  // Pop sequencer: exactly one pop per byte, even with ready held high.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (bus.ready) state_nx = POP;
      POP:     state_nx = WAIT;
      WAIT:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Byte decode, evaluated only while the latched byte is being popped.
  always_comb begin
    ext_nx       = ext_q;
    brk_nx       = brk_q;
    dec_fire     = 1'b0;
    dec_make     = 1'b0;
    dec_upd_last = 1'b0;
    dec_new      = 1'b0;
    dec_ins      = 1'b0;
    dec_rem      = 1'b0;
    dec_drop     = 1'b0;
    dec_kerr     = 1'b0;
`ifdef PS2_TRK_REPEAT_EN
    dec_rep      = 1'b0;
`endif
    if (state == POP) begin
      unique case (byte_q)
        8'hE0: ext_nx = 1'b1;
        8'hF0: brk_nx = 1'b1;
        8'h00, 8'hFF: begin
          dec_kerr = 1'b1;
          ext_nx   = 1'b0;
          brk_nx   = 1'b0;
        end
        default: begin
          ext_nx = 1'b0;
          brk_nx = 1'b0;
          if (brk_q) begin
            dec_fire = 1'b1;
            dec_rem  = 1'b1;
          end else if (hit_any) begin
`ifdef PS2_TRK_REPEAT_EN
            dec_fire     = 1'b1;
            dec_make     = 1'b1;
            dec_rep      = 1'b1;
            dec_upd_last = 1'b1;
`endif
          end else begin
            dec_fire     = 1'b1;
            dec_make     = 1'b1;
            dec_upd_last = 1'b1;
            dec_new      = 1'b1;
            dec_ins      = found_free;
            dec_drop     = !found_free;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      nextdata_q  <= 1'b1;
      byte_q      <= '0;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      slot_vld    <= '0;
      event_valid <= 1'b0;
      event_make  <= 1'b0;
      event_code  <= '0;
      last_code   <= '0;
      press_cnt   <= '0;
      drop_err    <= 1'b0;
      kbd_err     <= 1'b0;
    end else begin
      state <= state_nx;
      // Strobe is registered from the next state so it is low exactly in POP.
      nextdata_q <= (state_nx != POP);
      if (state == IDLE && bus.ready) byte_q <= bus.data;
      ext_q       <= ext_nx;
      brk_q       <= brk_nx;
      event_valid <= dec_fire;
      if (dec_fire) begin
        event_make <= dec_make;
        event_code <= cur_code;
      end
      if (dec_upd_last) last_code <= cur_code;
      if (dec_new) press_cnt <= press_cnt + CNT_W'(1);
      if (dec_drop) drop_err <= 1'b1;
      if (dec_kerr) kbd_err <= 1'b1;
      for (int unsigned i = 0; i < MAX_KEYS; i++) begin
        if (dec_rem && hit[i]) slot_vld[i] <= 1'b0;
        if (dec_ins && ins_oh[i]) slot_vld[i] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < MAX_KEYS; i++)
      if (dec_ins && ins_oh[i]) slot_code[i] <= cur_code;
  end

`ifdef PS2_TRK_REPEAT_EN
  always_ff @(posedge clk) begin
    if (rst) event_repeat <= 1'b0;
    else if (dec_fire) event_repeat <= dec_rep;
  end
`else
  assign event_repeat = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_key_tracker.sv
module tb_ps2_key_tracker;
  localparam int MAXK = 4;
  localparam int CW   = 8;
  localparam int HW   = $clog2(MAXK + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          event_valid, event_make, event_repeat;
  logic [8:0]    event_code, last_code;
  logic          held_any;
  logic [HW-1:0] held_num;
  logic [CW-1:0] press_cnt;
  logic          drop_err, kbd_err;

  ps2_key_tracker_if bus ();

  ps2_key_tracker #(.MAX_KEYS(MAXK), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .event_valid  (event_valid),
    .event_make   (event_make),
    .event_repeat (event_repeat),
    .event_code   (event_code),
    .last_code    (last_code),
    .held_any     (held_any),
    .held_num     (held_num),
    .press_cnt    (press_cnt),
    .drop_err     (drop_err),
    .kbd_err      (kbd_err)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_bad = 0;
  int unsigned cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Controller FIFO model, event monitor and pop log.
  logic [7:0]  fifo[$];
  logic [10:0] obs[$];
  int unsigned pop_cyc[$];
  int          ev_consec = 0;
  logic        prev_ev   = 1'b0;

  initial begin
    bus.ready = 1'b0;
    bus.data  = 8'h00;
  end

  always @(negedge clk) begin
    if (bus.nextdata_n === 1'b0) begin
      pop_cyc.push_back(cyc);
      if (fifo.size() > 0) void'(fifo.pop_front());
    end
    bus.ready = (fifo.size() > 0);
    bus.data  = (fifo.size() > 0) ? fifo[0] : 8'h00;
    if (event_valid === 1'b1) obs.push_back({event_make, event_repeat, event_code});
    if (event_valid === 1'b1 && prev_ev) ev_consec++;
    prev_ev = (event_valid === 1'b1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference model: prefix flags, held set as a queue, expected event list.
  bit          m_ext, m_brk, m_drop, m_kerr;
  logic [8:0]  m_last;
  int          m_cnt;
  logic [8:0]  m_held[$];
  logic [10:0] exp_ev[$];

  task automatic model_reset();
    m_ext = 0; m_brk = 0; m_drop = 0; m_kerr = 0;
    m_last = '0; m_cnt = 0;
    m_held.delete();
    exp_ev.delete();
  endtask

  task automatic model_byte(input logic [7:0] b);
    logic [8:0] c;
    int idx;
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else if (b == 8'h00 || b == 8'hFF) begin
      m_kerr = 1; m_ext = 0; m_brk = 0;
    end else begin
      c = {m_ext, b};
      idx = -1;
      foreach (m_held[j]) if (m_held[j] == c) idx = j;
      if (m_brk) begin
        if (idx >= 0) m_held.delete(idx);
        exp_ev.push_back({2'b00, c});
      end else if (idx >= 0) begin
`ifdef PS2_TRK_REPEAT_EN
        exp_ev.push_back({2'b11, c});
        m_last = c;
`endif
      end else begin
        m_cnt++;
        if (m_held.size() < MAXK) m_held.push_back(c);
        else m_drop = 1;
        exp_ev.push_back({2'b10, c});
        m_last = c;
      end
      m_ext = 0; m_brk = 0;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    fifo.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    obs.delete();
    pop_cyc.delete();
    model_reset();
  endtask

  task automatic drain(input string nm);
    int k = 0;
    while (fifo.size() != 0 && k < 5000) begin
      @(negedge clk);
      k++;
    end
    chk({nm, "_drain"}, fifo.size(), 0);
    repeat (6) @(negedge clk);
  endtask

  typedef struct {
    logic [63:0] seq;
    int          len;
    int          n_ev;
    int          held;
    int          cnt;
    bit          drop;
    bit          kerr;
    logic [8:0]  last;
    logic [10:0] first_ev;
    logic [10:0] last_ev;
  } vec_t;

  function automatic vec_t mk(input logic [63:0] seq, input int len, input int n_ev,
                              input int held, input int cnt, input bit drop, input bit kerr,
                              input logic [8:0] last, input logic [10:0] f, input logic [10:0] l);
    vec_t v;
    v.seq = seq; v.len = len; v.n_ev = n_ev; v.held = held; v.cnt = cnt;
    v.drop = drop; v.kerr = kerr; v.last = last; v.first_ev = f; v.last_ev = l;
    return v;
  endfunction

  vec_t vecs[6];
  logic [7:0] keys[7];

  initial begin
    logic [7:0] b;
    int unsigned r;
    string nm;

`ifdef PS2_TRK_REPEAT_EN
    vecs[3] = mk(64'h1C1C1C, 3, 3, 1, 1, 0, 0, 9'h01C, 11'h41C, 11'h61C);
`else
    vecs[3] = mk(64'h1C1C1C, 3, 1, 1, 1, 0, 0, 9'h01C, 11'h41C, 11'h41C);
`endif
    vecs[0] = mk(64'h1CF01C,     3, 2, 0, 1, 0, 0, 9'h01C, 11'h41C, 11'h01C);
    vecs[1] = mk(64'hE075E0F075, 5, 2, 0, 1, 0, 0, 9'h175, 11'h575, 11'h175);
    vecs[2] = mk(64'h1C3221232B, 5, 5, 4, 5, 1, 0, 9'h02B, 11'h41C, 11'h42B);
    vecs[4] = mk(64'h00,         1, 0, 0, 0, 0, 1, 9'h000, 11'h000, 11'h000);
    vecs[5] = mk(64'h75E075,     3, 2, 2, 2, 0, 0, 9'h175, 11'h475, 11'h575);
    keys = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h2B, 8'h75, 8'h6B};

    // Reset state
    do_reset();
    @(negedge clk);
    chk("rst_nextdata_n", bus.nextdata_n, 1);
    chk("rst_event_valid", event_valid, 0);
    chk("rst_held_num", held_num, 0);
    chk("rst_held_any", held_any, 0);
    chk("rst_press_cnt", press_cnt, 0);
    chk("rst_drop_err", drop_err, 0);
    chk("rst_kbd_err", kbd_err, 0);
    chk("rst_last_code", last_code, 0);
    repeat (3) @(negedge clk);
    chk("idle_no_pop", pop_cyc.size(), 0);

    // Table-driven byte sequences
    for (int v = 0; v < 6; v++) begin
      nm = $sformatf("vec%0d", v);
      do_reset();
      for (int i = 0; i < vecs[v].len; i++) begin
        b = vecs[v].seq[8*(vecs[v].len-1-i) +: 8];
        fifo.push_back(b);
      end
      drain(nm);
      chk({nm, "_n_ev"}, obs.size(), vecs[v].n_ev);
      chk({nm, "_held_num"}, held_num, vecs[v].held);
      chk({nm, "_held_any"}, held_any, vecs[v].held != 0);
      chk({nm, "_press_cnt"}, press_cnt, vecs[v].cnt);
      chk({nm, "_drop_err"}, drop_err, vecs[v].drop);
      chk({nm, "_kbd_err"}, kbd_err, vecs[v].kerr);
      chk({nm, "_last_code"}, last_code, vecs[v].last);
      chk({nm, "_pops"}, pop_cyc.size(), vecs[v].len);
      if (vecs[v].n_ev > 0 && obs.size() > 0) begin
        chk({nm, "_first_ev"}, obs[0], vecs[v].first_ev);
        chk({nm, "_last_ev"}, obs[obs.size()-1], vecs[v].last_ev);
      end
    end

    // Cycle-exact latency of a single byte
    do_reset();
    repeat (2) @(posedge clk);
    #1 fifo.push_back(8'h1C);
    @(negedge clk);
    chk("lat_t_nextdata_n", bus.nextdata_n, 1);
    @(negedge clk);
    chk("lat_t1_nextdata_n", bus.nextdata_n, 0);
    chk("lat_t1_event_valid", event_valid, 0);
    chk("lat_t1_held_num", held_num, 0);
    @(negedge clk);
    chk("lat_t2_nextdata_n", bus.nextdata_n, 1);
    chk("lat_t2_event_valid", event_valid, 1);
    chk("lat_t2_event_code", event_code, 9'h01C);
    chk("lat_t2_event_make", event_make, 1);
    chk("lat_t2_event_repeat", event_repeat, 0);
    chk("lat_t2_held_num", held_num, 1);
    chk("lat_t2_press_cnt", press_cnt, 1);
    @(negedge clk);
    chk("lat_t3_event_valid", event_valid, 0);

    // ready held high over queued bytes, ending with an error byte
    do_reset();
    fifo.push_back(8'h1C); fifo.push_back(8'h32);
    fifo.push_back(8'h21); fifo.push_back(8'h00);
    drain("stream");
    chk("stream_pops", pop_cyc.size(), 4);
    for (int i = 1; i < pop_cyc.size(); i++)
      chk($sformatf("stream_gap%0d", i), pop_cyc[i] - pop_cyc[i-1], 3);
    chk("stream_kbd_err", kbd_err, 1);
    chk("stream_n_ev", obs.size(), 3);
    chk("stream_held_num", held_num, 3);

    // Reset asserted while the byte is being popped
    do_reset();
    #1 fifo.push_back(8'h1C);
    @(negedge clk);
    @(negedge clk);
    chk("rstpop_nextdata_n_low", bus.nextdata_n, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("rstpop_nextdata_n", bus.nextdata_n, 1);
    chk("rstpop_event_valid", event_valid, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("rstpop_n_ev", obs.size(), 0);
    chk("rstpop_held_num", held_num, 0);
    chk("rstpop_press_cnt", press_cnt, 0);

    // Randomized stream against the reference model
    do_reset();
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r < 15) b = 8'hE0;
      else if (r < 45) b = 8'hF0;
      else if (r == 45) b = 8'h00;
      else if (r == 46) b = 8'hFF;
      else b = keys[$urandom_range(0, 6)];
      model_byte(b);
      @(posedge clk); #1;
      fifo.push_back(b);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    drain("rand");
    chk("rand_n_ev", obs.size(), exp_ev.size());
    for (int i = 0; i < obs.size() && i < exp_ev.size(); i++)
      chk($sformatf("rand_ev%0d", i), obs[i], exp_ev[i]);
    chk("rand_held_num", held_num, m_held.size());
    chk("rand_press_cnt", press_cnt, m_cnt % (1 << CW));
    chk("rand_drop_err", drop_err, m_drop);
    chk("rand_kbd_err", kbd_err, m_kerr);
    chk("rand_last_code", last_code, m_last);
    chk("rand_pops", pop_cyc.size(), 400);

    chk("event_valid_consecutive", ev_consec, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
